capture_controller: RTL and testbench
=====================================

// Module: capture_controller
// PURPOSE
// Host-side sequencer for the pixel-array data path FSM (erase/expose/convert/read).
// - Accepts a capture command (frame count, CDS on/off) over a valid/ready handshake.
// - Starts the data path and holds its continuous-mode input so exactly N frames run.
// - Captures ADC pixel data during read phases into a FIFO.
// - Streams the pixels out over a valid/ready interface with an end-of-frame marker.
// PARAMETERS
// PIXEL_COUNT  4  pixels per frame; must match the data path instance
// DATA_W       8  ADC pixel width
// FIFO_DEPTH   8  output FIFO entries, power of 2, >= 2
// FRAME_W      8  width of frame-count fields
// PORTS
// clk              in   1                    system clock, rising edge
// reset            in   1                    asynchronous, active-low reset
// cmd_valid        in   1                    host command valid
// cmd_ready        out  1                    controller can accept a command
// cmd_frames       in   FRAME_W              number of frames to capture
// cmd_cds          in   1                    enable correlated double sampling
// abort            in   1                    stop after the frame in progress
// dp_enable        out  1                    start pulse to the data path
// dp_cds           out  1                    CDS select to the data path
// dp_cont_mode     out  1                    continuous-mode select to the data path
// dp_idle          in   1                    data path is in its idle state
// dp_read          in   1                    data path is in its read phase
// dp_pixel_select  in   $clog2(PIXEL_COUNT)  pixel index being read
// pix_data         in   DATA_W               ADC value for dp_pixel_select; valid while dp_read
// out_valid        out  1                    pixel stream valid
// out_ready        in   1                    pixel stream ready
// out_data         out  DATA_W               pixel value
// out_last         out  1                    last pixel of a frame
// busy             out  1                    state != IDLE
// done             out  1                    1-cycle pulse when a command completes
// overflow         out  1                    sticky: a pixel was dropped on a full FIFO
// frames_done      out  FRAME_W              frames completed in the current or last command
// BEHAVIOUR
// Reset (reset=0, async)
// - FSM to IDLE; FIFO emptied.
// - All outputs 0: cmd_ready, dp_*, out_valid, out_data, out_last, busy, done, overflow, frames_done.
// - Reset mid-operation abandons the command. The data path is not reset by this block.
// FSM states: IDLE, ARM, RUN, DRAIN.
// IDLE
// - cmd_ready = dp_idle.
// - On cmd_valid & cmd_ready & cmd_frames != 0: latch remaining = cmd_frames and dp_cds = cmd_cds;
//   clear frames_done and overflow; go to ARM.
// - A command with cmd_frames == 0 is consumed and has no other effect.
// ARM (1 cycle)
// - dp_enable = 1.
// - dp_cont_mode = (remaining > 1).
// - Go to RUN.
// RUN
// - dp_cont_mode = (remaining > 1), combinational on remaining.
// - Frame end is any cycle with dp_read & dp_pixel_select == PIXEL_COUNT-1.
//   At frame end: remaining -= 1, frames_done += 1.
// - When remaining == 0 and dp_idle: go to DRAIN.
// - abort (level, sampled in ARM or RUN): remaining forced to 1 and dp_cont_mode = 0 from the
//   next cycle. The frame in progress completes and its pixels are captured.
//   If abort arrives in RUN when remaining == 0, it is ignored.
// DRAIN
// - Wait until the FIFO is empty, then pulse done for 1 cycle and go to IDLE.
// - dp_cds returns to 0 in IDLE.
// - cmd_ready is 0 in every state except IDLE.
// Capture
// - Every cycle with dp_read=1 pushes {pix_data, last = (dp_pixel_select == PIXEL_COUNT-1)}.
// - Latency: a pixel read in cycle N shows out_valid in cycle N+1 if the FIFO was empty.
// FIFO
// - out_valid = !empty; out_data/out_last come from the head entry.
// - Pop on out_valid & out_ready.
// - Push while full with a simultaneous pop is accepted (no drop).
// - Push while full without a pop drops the new pixel and sets overflow=1.
// - Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
// - frames_done saturates at 2^FRAME_W-1.
// TESTING
// 1. frames=1, cds=0, out_ready=1, pix 0x11,0x22,0x33,0x44 -> one dp_enable pulse, dp_cont_mode=0,
//    out 11,22,33,44 with out_last on 44 only, done pulse, frames_done=1, busy=0.
// 2. frames=3, cds=1 -> dp_cds=1 throughout, dp_cont_mode=1 until the end of frame 2,
//    12 pixels out, 3 out_last, frames_done=3.
// 3. DEPTH=8, out_ready=0, frames=3 -> first 8 pixels retained in order, overflow=1 at the 9th;
//    then out_ready=1 -> 8 pixels out, done.
// 4. frames=5, abort during frame 2 expose -> dp_cont_mode=0 next cycle, frame 2 completes,
//    8 pixels out, frames_done=2, done.
// 5. cmd_frames=0 -> consumed, busy stays 0. cmd_valid while busy -> cmd_ready=0, not taken.
// 6. reset low mid-RUN -> all outputs 0, FIFO empty; after release a frames=1 command completes
//    normally.

Source files
------------

// File: rtl/capture_controller.sv
// Host-side sequencer for the pixel-array data path: runs N frames per command,
// buffers read-phase pixels in a FIFO and streams them out with an end-of-frame marker.
module capture_controller #(
    parameter int unsigned PIXEL_COUNT = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FRAME_W     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [FRAME_W-1:0]             cmd_frames,
    input  logic                           cmd_cds,
    input  logic                           abort,
    output logic                           dp_enable,
    output logic                           dp_cds,
    output logic                           dp_cont_mode,
    input  logic                           dp_idle,
    input  logic                           dp_read,
    input  logic [$clog2(PIXEL_COUNT)-1:0] dp_pixel_select,
    input  logic [DATA_W-1:0]              pix_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [FRAME_W-1:0]             frames_done
);

    localparam int unsigned SEL_W = $clog2(PIXEL_COUNT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(PIXEL_COUNT - 1);
    localparam logic [FRAME_W-1:0] FRAMES_MAX = {FRAME_W{1'b1}};
    localparam logic [FRAME_W-1:0] ONE_FRAME  = FRAME_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } entry_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] remaining_q, remaining_d;
    logic [FRAME_W-1:0] frames_done_q, frames_done_d;
    logic               overflow_q, overflow_d;
    logic               dp_cds_q, dp_cds_d;
    logic               dp_enable_q, dp_enable_d;
    logic               dp_cont_mode_q, dp_cont_mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [FIFO_DEPTH];
    entry_t             wr_entry;
    entry_t             head;

    logic fifo_empty, fifo_full, pop, push_ok, frame_end, accept;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        pop        = !fifo_empty && out_ready;
        frame_end  = dp_read && (dp_pixel_select == LAST_SEL);
        push_ok    = dp_read && (!fifo_full || pop);
        accept     = (state_q == IDLE) && cmd_valid && cmd_ready_q;
        wr_entry   = '{data: pix_data, last: frame_end};
        head       = mem_q[rd_ptr_q];
    end

    // Sequencer next state and registered-output next values
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        frames_done_d = frames_done_q;
        overflow_d    = overflow_q;
        dp_cds_d      = dp_cds_q;
        done_d        = 1'b0;

        if (dp_read && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept && (cmd_frames != '0)) begin
                    remaining_d   = cmd_frames;
                    dp_cds_d      = cmd_cds;
                    frames_done_d = '0;
                    overflow_d    = 1'b0;
                    state_d       = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    remaining_d = ONE_FRAME;
                end
                state_d = RUN;
            end
            RUN: begin
                // Abort only shortens the run; the frame in flight still counts
                if (frame_end && (remaining_q != '0)) begin
                    remaining_d = (abort && (remaining_q > ONE_FRAME)) ? ONE_FRAME
                                                                      : remaining_q - ONE_FRAME;
                end else if (abort && (remaining_q != '0)) begin
                    remaining_d = ONE_FRAME;
                end
                if (frame_end && (frames_done_q != FRAMES_MAX)) begin
                    frames_done_d = frames_done_q + ONE_FRAME;
                end
                if ((remaining_q == '0) && dp_idle) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            dp_cds_d = 1'b0;
        end
        dp_enable_d    = (state_d == ARM);
        dp_cont_mode_d = ((state_d == ARM) || (state_d == RUN)) && (remaining_d > ONE_FRAME);
        busy_d         = (state_d != IDLE);
        cmd_ready_d    = (state_d == IDLE) && dp_idle;
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            frames_done_q  <= '0;
            overflow_q     <= 1'b0;
            dp_cds_q       <= 1'b0;
            dp_enable_q    <= 1'b0;
            dp_cont_mode_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cmd_ready_q    <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            frames_done_q  <= frames_done_d;
            overflow_q     <= overflow_d;
            dp_cds_q       <= dp_cds_d;
            dp_enable_q    <= dp_enable_d;
            dp_cont_mode_q <= dp_cont_mode_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cmd_ready_q    <= cmd_ready_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Storage is unreset; the read side is masked while empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign dp_enable    = dp_enable_q;
    assign dp_cds       = dp_cds_q;
    assign dp_cont_mode = dp_cont_mode_q;
    assign out_valid    = !fifo_empty;
    assign out_data     = fifo_empty ? '0 : head.data;
    assign out_last     = !fifo_empty && head.last;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign frames_done  = frames_done_q;

endmodule

// File: tb/tb_capture_controller.sv
// Scoreboard bench for capture_controller with a behavioural data-path model.
`timescale 1ns/1ps
module tb_capture_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_cds, abort;
    logic [7:0] cmd_frames;
    logic       dp_enable, dp_cds, dp_cont_mode, dp_idle, dp_read;
    logic [1:0] dp_pixel_select;
    logic [7:0] pix_data;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic       busy, done, overflow;
    logic [7:0] frames_done;

    int tests_run = 0;
    int tests_failed = 0;
    int pop_cnt = 0;
    int last_cnt = 0;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    capture_controller #(
        .PIXEL_COUNT(4), .DATA_W(8), .FIFO_DEPTH(8), .FRAME_W(8)
    ) dut (
        .clk(clk), .reset(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_frames(cmd_frames),
        .cmd_cds(cmd_cds), .abort(abort),
        .dp_enable(dp_enable), .dp_cds(dp_cds), .dp_cont_mode(dp_cont_mode),
        .dp_idle(dp_idle), .dp_read(dp_read), .dp_pixel_select(dp_pixel_select),
        .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .overflow(overflow), .frames_done(frames_done)
    );

    // Data path model: erase(2) -> expose(3) -> convert(1) -> read(4), repeats while cont_mode
    typedef enum {DP_IDLE, DP_ERASE, DP_EXPOSE, DP_CONVERT, DP_READ} dp_ph_t;
    dp_ph_t     dp_ph;
    int         dp_cnt;
    int         dp_frame;
    logic [1:0] dp_sel;

    function automatic logic [7:0] pix_val(input int fr, input int sel);
        return 8'((sel + 1) * 17 + fr * 64);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_ph <= DP_IDLE; dp_cnt <= 0; dp_frame <= 0; dp_sel <= 2'd0;
        end else begin
            case (dp_ph)
                DP_IDLE: if (dp_enable) begin dp_ph <= DP_ERASE; dp_cnt <= 0; dp_frame <= 0; end
                DP_ERASE: if (dp_cnt == 1) begin dp_ph <= DP_EXPOSE; dp_cnt <= 0; end
                          else dp_cnt <= dp_cnt + 1;
                DP_EXPOSE: if (dp_cnt == 2) begin dp_ph <= DP_CONVERT; dp_cnt <= 0; end
                           else dp_cnt <= dp_cnt + 1;
                DP_CONVERT: begin dp_ph <= DP_READ; dp_sel <= 2'd0; end
                DP_READ: begin
                    if (dp_sel == 2'd3) begin
                        dp_sel <= 2'd0;
                        if (dp_cont_mode) begin dp_ph <= DP_ERASE; dp_frame <= dp_frame + 1; end
                        else dp_ph <= DP_IDLE;
                    end else begin
                        dp_sel <= dp_sel + 2'd1;
                    end
                end
                default: dp_ph <= DP_IDLE;
            endcase
        end
    end

    assign dp_idle         = (dp_ph == DP_IDLE);
    assign dp_read         = (dp_ph == DP_READ);
    assign dp_pixel_select = dp_sel;
    assign pix_data        = pix_val(dp_frame, int'(dp_sel));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frames(input int first_fr, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            exp_q.push_back({pix_val(first_fr + i / 4, i % 4), (i % 4) == 3});
        end
    endtask

    // Output monitor: pops the scoreboard whenever a pixel transfers
    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                pop_cnt++;
                if (out_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    check("pixel_unexpected", 32'({out_data, out_last}), 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 32'({out_data, out_last}), 32'(e));
                end
            end
        end
    endtask

    task automatic send_cmd(input logic [7:0] frames, input logic cds);
        int n = 0;
        cmd_valid = 1'b1; cmd_frames = frames; cmd_cds = cds;
        while (!cmd_ready && n < 50) begin step(); n++; end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0; cmd_frames = 8'd0; cmd_cds = 1'b0;
    endtask

    task automatic run_to_done(input logic cds_exp, output int en_cnt, output int cds_bad,
                               output logic [7:0] cont_hist, output int n_fe);
        int cyc = 0;
        en_cnt = 0; cds_bad = 0; cont_hist = '0; n_fe = 0;
        while (!done && cyc < 400) begin
            if (dp_enable) en_cnt++;
            if (busy && (dp_cds != cds_exp)) cds_bad++;
            if (dp_read && dp_pixel_select == 2'd3) begin
                if (n_fe < 8) cont_hist[n_fe] = dp_cont_mode;
                n_fe++;
            end
            step();
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_frames(input logic [7:0] n, input bool_idle);
        int cyc = 0;
        while (!(frames_done == n && (!bool_idle || dp_idle)) && cyc < 400) begin step(); cyc++; end
        check("wait_frames", 32'(frames_done), 32'(n));
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({cmd_ready, dp_enable, dp_cds, dp_cont_mode, out_valid, out_data,
                    out_last, busy, done, overflow, frames_done});
    endfunction

    int         en_cnt, cds_bad, n_fe, cyc, rdy_hi;
    logic [7:0] cont_hist;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_frames = 8'd0; cmd_cds = 1'b0;
        abort = 1'b0; out_ready = 1'b1;
        fork
            monitor();
        join_none
        step(); step();
        check("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b1;
        step(); step();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1: single frame, no CDS
        pop_cnt = 0; last_cnt = 0;
        push_frames(0, 4);
        send_cmd(8'd1, 1'b0);
        run_to_done(1'b0, en_cnt, cds_bad, cont_hist, n_fe);
        check("t1_enable_pulses", 32'(en_cnt), 32'd1);
        check("t1_cont_at_end", 32'(cont_hist[0]), 32'd0);
        check("t1_frames_done", 32'(frames_done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_pixels", 32'(pop_cnt), 32'd4);
        check("t1_lasts", 32'(last_cnt), 32'd1);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        // 2: three frames with CDS
        pop_cnt = 0; last_cnt = 0;
        push_frames(0, 12);
        send_cmd(8'd3, 1'b1);
        run_to_done(1'b1, en_cnt, cds_bad, cont_hist, n_fe);
        check("t2_cds_held", 32'(cds_bad), 32'd0);
        check("t2_cont_hist", 32'(cont_hist[2:0]), 32'b011);
        check("t2_frames_done", 32'(frames_done), 32'd3);
        check("t2_pixels", 32'(pop_cnt), 32'd12);
        check("t2_lasts", 32'(last_cnt), 32'd3);
        step();
        check("t2_cds_idle", 32'(dp_cds), 32'd0);

        // 3: FIFO overflow with stalled output
        pop_cnt = 0; last_cnt = 0; out_ready = 1'b0;
        push_frames(0, 8);
        send_cmd(8'd3, 1'b0);
        wait_frames(8'd2, 1'b0);
        check("t3_no_ovf_at_8", 32'(overflow), 32'd0);
        wait_frames(8'd3, 1'b1);
        step(); step(); step();
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_held_valid", 32'(out_valid), 32'd1);
        check("t3_draining", 32'(busy), 32'd1);
        out_ready = 1'b1;
        run_to_done(1'b0, en_cnt, cds_bad, cont_hist, n_fe);
        check("t3_pixels", 32'(pop_cnt), 32'd8);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: abort during the second frame's expose
        pop_cnt = 0; last_cnt = 0;
        push_frames(0, 8);
        send_cmd(8'd5, 1'b0);
        check("t4_ovf_cleared", 32'(overflow), 32'd0);
        cyc = 0;
        while (!(dp_frame == 1 && dp_ph == DP_EXPOSE) && cyc < 400) begin step(); cyc++; end
        check("t4_reach_expose", 32'(dp_frame), 32'd1);
        check("t4_cont_before", 32'(dp_cont_mode), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_cont_after", 32'(dp_cont_mode), 32'd0);
        run_to_done(1'b0, en_cnt, cds_bad, cont_hist, n_fe);
        check("t4_frames_done", 32'(frames_done), 32'd2);
        check("t4_pixels", 32'(pop_cnt), 32'd8);

        // 5: zero-frame command, and a command offered while busy
        en_cnt = 0;
        send_cmd(8'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (busy || dp_enable) en_cnt++;
            step();
        end
        check("t5_zero_ignored", 32'(en_cnt), 32'd0);
        check("t5_zero_ready", 32'(cmd_ready), 32'd1);
        pop_cnt = 0;
        push_frames(0, 4);
        send_cmd(8'd1, 1'b0);
        cmd_valid = 1'b1; cmd_frames = 8'd2; rdy_hi = 0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_ready) rdy_hi++;
            step();
        end
        cmd_valid = 1'b0; cmd_frames = 8'd0;
        check("t5_busy_not_ready", 32'(rdy_hi), 32'd0);
        run_to_done(1'b0, en_cnt, cds_bad, cont_hist, n_fe);
        check("t5_frames_done", 32'(frames_done), 32'd1);
        check("t5_pixels", 32'(pop_cnt), 32'd4);

        // 6: reset in the middle of a run, then a normal command
        push_frames(0, 12);
        send_cmd(8'd3, 1'b0);
        wait_frames(8'd1, 1'b0);
        step(); step();
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", all_outputs(), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        pop_cnt = 0; last_cnt = 0;
        push_frames(0, 4);
        send_cmd(8'd1, 1'b0);
        run_to_done(1'b0, en_cnt, cds_bad, cont_hist, n_fe);
        check("t6_frames_done", 32'(frames_done), 32'd1);
        check("t6_pixels", 32'(pop_cnt), 32'd4);
        check("t6_lasts", 32'(last_cnt), 32'd1);

        step(); step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
